// File: rtl/subtractor_array_if.sv
// Beat-level bus for subtractor_array.
// master drives operands and strobes: de, x, y, bin, mode (+ last).
// slave drives results: oe, diff, bout (+ sad, sad_oe).
// Optional SAD signals exist only when SUBTRACTOR_SAD_EN is defined.
interface subtractor_array_if #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned LANES = 4
`ifdef SUBTRACTOR_SAD_EN
  ,
  parameter int unsigned SAD_W = WIDTH + 8
`endif
);
  localparam int unsigned BUS_W = LANES * WIDTH;

  logic             de;
  logic [BUS_W-1:0] x;
  logic [BUS_W-1:0] y;
  logic             bin;
  logic [1:0]       mode;
  logic             oe;
  logic [BUS_W-1:0] diff;
  logic [LANES-1:0] bout;
`ifdef SUBTRACTOR_SAD_EN
  logic             last;
  logic [SAD_W-1:0] sad;
  logic             sad_oe;

  modport master (output de, x, y, bin, mode, last, input oe, diff, bout, sad, sad_oe);
  modport slave  (input de, x, y, bin, mode, last, output oe, diff, bout, sad, sad_oe);
`else
  modport master (output de, x, y, bin, mode, input oe, diff, bout);
  modport slave  (input de, x, y, bin, mode, output oe, diff, bout);
`endif
endinterface

// File: rtl/subtractor_array.sv
// subtractor_array: LANES-wide pipelined subtractor with wrap / saturate-at-zero /
// absolute-difference modes, optionally chained into one wide borrow-rippled subtractor.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - subtractor_array_if.slave: de/x/y/bin/mode in, oe/diff/bout out
// Latency from sampling edge to oe: 2 (OUT_REG=0) or 3 (OUT_REG=1), throughput 1.
// Optional feature macro SUBTRACTOR_SAD_EN adds bus.last in and bus.sad/bus.sad_oe out:
// a saturating sum of per-lane absolute differences, reported and cleared on last.
module subtractor_array #(
  parameter int unsigned WIDTH   = 15,
  parameter int unsigned LANES   = 4,
  parameter int unsigned CHAIN   = 0,
  parameter int unsigned OUT_REG = 1
`ifdef SUBTRACTOR_SAD_EN
  ,
  parameter int unsigned SAD_W   = WIDTH + 8
`endif
) (
  input logic               clk,
  input logic               rst_n,
  subtractor_array_if.slave bus
);
  localparam int unsigned BUS_W    = LANES * WIDTH;
  localparam int unsigned RAW_W    = WIDTH + 1;
  localparam logic [1:0]  MODE_SAT = 2'b01;
  localparam logic [1:0]  MODE_ABS = 2'b10;

  logic             s1_v;
  logic [BUS_W-1:0] s1_x;
  logic [BUS_W-1:0] s1_y;
  logic             s1_bin;
  logic [1:0]       s1_mode;

  logic [BUS_W-1:0] diff_c;
  logic [LANES-1:0] bout_c;

  logic             s2_v;
  logic [BUS_W-1:0] s2_diff;
  logic [LANES-1:0] s2_bout;

  logic             o_v;
  logic [BUS_W-1:0] o_diff;
  logic [LANES-1:0] o_bout;

`ifdef SUBTRACTOR_SAD_EN
  // Wide enough to hold the accumulator plus one beat's lane sum without overflow.
  localparam int unsigned         EXT_W   = ((SAD_W > WIDTH + LANES) ? SAD_W : WIDTH + LANES) + 1;
  localparam logic [EXT_W-1:0]    SAD_MAX = EXT_W'({SAD_W{1'b1}});

  logic             s1_last;
  logic             s2_last;
  logic [EXT_W-1:0] abs_sum_c;
  logic [EXT_W-1:0] s2_abs_sum;
  logic [EXT_W-1:0] total_c;
  logic [SAD_W-1:0] sad_total_c;
  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] o_sad;
  logic             o_sad_oe;
`endif

  // Stage 1: capture operands on DE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_bin  <= 1'b0;
      s1_mode <= 2'b00;
`ifdef SUBTRACTOR_SAD_EN
      s1_last <= 1'b0;
`endif
    end else begin
      s1_v <= bus.de;
      if (bus.de) begin
        s1_x    <= bus.x;
        s1_y    <= bus.y;
        s1_bin  <= bus.bin;
        s1_mode <= bus.mode;
`ifdef SUBTRACTOR_SAD_EN
        s1_last <= bus.last;
`endif
      end
    end
  end

  // Per-lane subtract, borrow either shared (independent lanes) or rippled (chained).
  always_comb begin : lane_math
    logic             b;
    logic [RAW_W-1:0] raw;
    logic [RAW_W-1:0] neg;
    logic [WIDTH-1:0] mag;
    diff_c = '0;
    bout_c = '0;
    b      = s1_bin;
    raw    = '0;
    neg    = '0;
    mag    = '0;
`ifdef SUBTRACTOR_SAD_EN
    abs_sum_c = '0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      raw = {1'b0, s1_x[i*WIDTH +: WIDTH]} - {1'b0, s1_y[i*WIDTH +: WIDTH]} - RAW_W'(b);
      neg = -raw;
      // Only raw = -2^WIDTH yields a magnitude with the top bit set; clamp it.
      mag = neg[WIDTH] ? '1 : neg[WIDTH-1:0];
      bout_c[i] = raw[WIDTH];
      if (CHAIN != 0) begin
        diff_c[i*WIDTH +: WIDTH] = raw[WIDTH-1:0];
      end else begin
        case (s1_mode)
          MODE_SAT: diff_c[i*WIDTH +: WIDTH] = raw[WIDTH] ? '0 : raw[WIDTH-1:0];
          MODE_ABS: diff_c[i*WIDTH +: WIDTH] = raw[WIDTH] ? mag : raw[WIDTH-1:0];
          default:  diff_c[i*WIDTH +: WIDTH] = raw[WIDTH-1:0];
        endcase
      end
`ifdef SUBTRACTOR_SAD_EN
      abs_sum_c = abs_sum_c + EXT_W'(raw[WIDTH] ? mag : raw[WIDTH-1:0]);
`endif
      b = (CHAIN != 0) ? raw[WIDTH] : s1_bin;
    end
  end

  // Stage 2: register mode-adjusted results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_diff <= '0;
      s2_bout <= '0;
`ifdef SUBTRACTOR_SAD_EN
      s2_last    <= 1'b0;
      s2_abs_sum <= '0;
`endif
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_diff <= diff_c;
        s2_bout <= bout_c;
`ifdef SUBTRACTOR_SAD_EN
        s2_last    <= s1_last;
        s2_abs_sum <= abs_sum_c;
`endif
      end
    end
  end

  // Stage 3: output register; results hold between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_v    <= 1'b0;
      o_diff <= '0;
      o_bout <= '0;
    end else begin
      o_v <= s2_v;
      if (s2_v) begin
        o_diff <= s2_diff;
        o_bout <= s2_bout;
      end
    end
  end

`ifdef SUBTRACTOR_SAD_EN
  // Saturating running total including the current beat.
  always_comb begin
    total_c     = EXT_W'(acc) + s2_abs_sum;
    sad_total_c = (total_c > SAD_MAX) ? '1 : total_c[SAD_W-1:0];
  end

  // Accumulator updates alongside stage 3; cleared after reporting a LAST beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      o_sad    <= '0;
      o_sad_oe <= 1'b0;
    end else begin
      o_sad_oe <= s2_v & s2_last;
      if (s2_v) begin
        acc <= s2_last ? '0 : sad_total_c;
        if (s2_last) begin
          o_sad <= sad_total_c;
        end
      end
    end
  end
`endif

  // Optional extra output stage.
  if (OUT_REG != 0) begin : g_out_reg
    logic             r_v;
    logic [BUS_W-1:0] r_diff;
    logic [LANES-1:0] r_bout;
`ifdef SUBTRACTOR_SAD_EN
    logic [SAD_W-1:0] r_sad;
    logic             r_sad_oe;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v    <= 1'b0;
        r_diff <= '0;
        r_bout <= '0;
`ifdef SUBTRACTOR_SAD_EN
        r_sad    <= '0;
        r_sad_oe <= 1'b0;
`endif
      end else begin
        r_v <= o_v;
        if (o_v) begin
          r_diff <= o_diff;
          r_bout <= o_bout;
        end
`ifdef SUBTRACTOR_SAD_EN
        r_sad_oe <= o_sad_oe;
        if (o_sad_oe) begin
          r_sad <= o_sad;
        end
`endif
      end
    end
    assign bus.oe   = r_v;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
`ifdef SUBTRACTOR_SAD_EN
    assign bus.sad    = r_sad;
    assign bus.sad_oe = r_sad_oe;
`endif
  end else begin : g_no_out_reg
    assign bus.oe   = o_v;
    assign bus.diff = o_diff;
    assign bus.bout = o_bout;
`ifdef SUBTRACTOR_SAD_EN
    assign bus.sad    = o_sad;
    assign bus.sad_oe = o_sad_oe;
`endif
  end
endmodule
